mips_rf_wport_arbiter: RTL and testbench

//   Shares the single register-file write port (wen/waddr/wdata) between the

---
 rtl/mips_rf_wport_arbiter.sv | 147 ++++++++++++++
 tb/tb_mips_rf_wport_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_rf_wport_arbiter.sv
// Register-file write-port arbiter: WB stage has priority, and long-latency unit results
// wait in a small FIFO that drains on free WB slots or by forcing a one-cycle pipeline stall.
module mips_rf_wport_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  wb_wen,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  input  logic        lu_issue,
  input  logic [4:0]  lu_issue_addr,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_waddr,
  input  logic [31:0] lu_wdata,
  output logic        pipe_stall,
  output logic [31:0] pend_mask,
  output logic [3:0]  rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  entry_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [STV_W-1:0]   starve_cnt;
  state_t             state;

  logic   wb_act, full, push, push_keep, pop, last_out;
  entry_t head;
  logic [31:0] clr_vec, set_vec;

  assign wb_act    = (|wb_wen) && (wb_waddr != 5'd0);
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign lu_ready  = resetn && !full;
  assign push      = lu_valid && lu_ready;
  // A result aimed at r0 is handshaken but never stored.
  assign push_keep = push && (lu_waddr != 5'd0);
  assign head      = mem[rd_ptr];
  assign last_out  = (count == CNT_W'(1)) && !push_keep;

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    pop        = 1'b0;
    pipe_stall = 1'b0;
    rf_wen     = 4'h0;
    rf_waddr   = 5'd0;
    rf_wdata   = 32'd0;
    if (resetn) begin
      unique case (state)
        IDLE: begin
          if (wb_act) begin
            rf_wen   = wb_wen;
            rf_waddr = wb_waddr;
            rf_wdata = wb_wdata;
          end
        end
        PEND: begin
          if (wb_act) begin
            rf_wen   = wb_wen;
            rf_waddr = wb_waddr;
            rf_wdata = wb_wdata;
          end else begin
            pop      = 1'b1;
            rf_wen   = 4'hF;
            rf_waddr = head.addr;
            rf_wdata = head.data;
          end
        end
        FORCE: begin
          pipe_stall = 1'b1;
          pop        = 1'b1;
          rf_wen     = 4'hF;
          rf_waddr   = head.addr;
          rf_wdata   = head.data;
        end
        default: ;
      endcase
    end
  end

  // Set is applied after clear, so a re-issue to the retiring register keeps its bit.
  always_comb begin
    clr_vec = 32'd0;
    set_vec = 32'd0;
    if (pop)
      clr_vec = 32'd1 << head.addr;
    if (lu_issue && (lu_issue_addr != 5'd0))
      set_vec = 32'd1 << lu_issue_addr;
  end

  // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      pend_mask  <= 32'd0;
    end else begin
      if (push_keep) wr_ptr <= wr_ptr + 1'b1;
      if (pop)       rd_ptr <= rd_ptr + 1'b1;
      count     <= count + CNT_W'(push_keep) - CNT_W'(pop);
      pend_mask <= (pend_mask & ~clr_vec) | set_vec;

      unique case (state)
        IDLE: begin
          if (push_keep) state <= PEND;
        end
        PEND: begin
          if (wb_act) begin
            starve_cnt <= starve_cnt + 1'b1;
            if (starve_cnt == STV_W'(STARVE_LIMIT - 1)) state <= FORCE;
          end else begin
            starve_cnt <= '0;
            if (last_out) state <= IDLE;
          end
        end
        FORCE: begin
          starve_cnt <= '0;
          state      <= last_out ? IDLE : PEND;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the storage array has no reset; the pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push_keep) mem[wr_ptr] <= '{addr: lu_waddr, data: lu_wdata};
  end

endmodule

// File: tb/tb_mips_rf_wport_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then randomized
// traffic, all compared every cycle against a queue-based model of the write-port rules.
module tb_mips_rf_wport_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  wb_wen;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        lu_issue;
  logic [4:0]  lu_issue_addr;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        pipe_stall;
  logic [31:0] pend_mask;
  logic [3:0]  rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  always #5 clk = ~clk;

  mips_rf_wport_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .resetn(resetn),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .lu_issue(lu_issue), .lu_issue_addr(lu_issue_addr),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
    .pipe_stall(pipe_stall), .pend_mask(pend_mask),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: buffered results as a queue, plus the starvation count and force flag.
  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  int          m_starve = 0;
  bit          m_force = 1'b0;
  logic [31:0] m_pend = 32'd0;

  logic        e_ready, e_stall;
  logic [3:0]  e_wen;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata;
  bit          e_pop;

  logic ready_smp = 1'b1;
  logic stall_smp = 1'b0;

  function automatic void model_eval();
    bit wb_act;
    e_ready = 1'b0; e_stall = 1'b0; e_wen = 4'h0; e_waddr = 5'd0; e_wdata = 32'd0; e_pop = 1'b0;
    if (resetn !== 1'b1) return;
    wb_act  = (wb_wen != 4'h0) && (wb_waddr != 5'd0);
    e_ready = (mq.size() < DEPTH);
    if (m_force) begin
      e_stall = 1'b1;
      e_pop   = 1'b1;
    end else if (mq.size() != 0 && !wb_act) begin
      e_pop = 1'b1;
    end
    if (e_pop && mq.size() != 0) begin
      e_wen = 4'hF; e_waddr = mq[0].addr; e_wdata = mq[0].data;
    end else if (wb_act) begin
      e_wen = wb_wen; e_waddr = wb_waddr; e_wdata = wb_wdata;
    end
  endfunction

  task automatic model_clear();
    mq.delete();
    m_starve = 0;
    m_force  = 1'b0;
    m_pend   = 32'd0;
  endtask

  task automatic model_step();
    int sz;
    bit wb_act, go_force;
    ent_t h;
    model_eval();
    sz       = mq.size();
    wb_act   = (wb_wen != 4'h0) && (wb_waddr != 5'd0);
    go_force = 1'b0;
    if (e_pop && sz != 0) begin
      h = mq.pop_front();
      m_pend[h.addr] = 1'b0;
      m_starve = 0;
    end else if (sz != 0 && wb_act) begin
      m_starve++;
      go_force = (m_starve == LIMIT);
    end
    if (lu_valid && e_ready && lu_waddr != 5'd0) mq.push_back('{addr: lu_waddr, data: lu_wdata});
    if (lu_issue && lu_issue_addr != 5'd0) m_pend[lu_issue_addr] = 1'b1;
    m_force = go_force;
  endtask

  always @(posedge clk) begin
    if (resetn !== 1'b1) model_clear();
    else model_step();
  end

  always @(negedge clk) begin
    if (resetn !== 1'b1) model_clear();
    model_eval();
    check("lu_ready",   lu_ready,   e_ready);
    check("pipe_stall", pipe_stall, e_stall);
    check("rf_wen",     rf_wen,     e_wen);
    check("rf_waddr",   rf_waddr,   e_waddr);
    check("rf_wdata",   rf_wdata,   e_wdata);
    check("pend_mask",  pend_mask,  m_pend);
    ready_smp = lu_ready;
    stall_smp = pipe_stall;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_wen = 4'h0; wb_waddr = 5'd0; wb_wdata = 32'd0;
    lu_issue = 1'b0; lu_issue_addr = 5'd0;
    lu_valid = 1'b0; lu_waddr = 5'd0; lu_wdata = 32'd0;
  endtask

  task automatic set_wb(input logic [3:0] w, input logic [4:0] a, input logic [31:0] d);
    wb_wen = w; wb_waddr = a; wb_wdata = d;
  endtask

  task automatic set_lu(input logic v, input logic [4:0] a, input logic [31:0] d);
    lu_valid = v; lu_waddr = a; lu_wdata = d;
  endtask

  initial begin
    int n;
    logic [4:0] ra;
    idle_inputs();

    // 1. reset, then idle, then a plain WB write passes straight through
    settle();
    check("t1_reset_ready", lu_ready, 1'b0);
    check("t1_reset_wen", rf_wen, 4'h0);
    next_cycle(); resetn = 1'b1;
    settle();
    check("t1_idle_ready", lu_ready, 1'b1);
    check("t1_idle_wen", rf_wen, 4'h0);
    check("t1_idle_pend", pend_mask, 32'd0);
    next_cycle(); set_wb(4'hF, 5'd3, 32'h11);
    settle();
    check("t1_wb_wen", rf_wen, 4'hF);
    check("t1_wb_waddr", rf_waddr, 5'd3);
    check("t1_wb_wdata", rf_wdata, 32'h11);

    // 2. single LU op, issued then returned with WB idle
    next_cycle(); idle_inputs(); lu_issue = 1'b1; lu_issue_addr = 5'd5;
    settle();
    next_cycle(); lu_issue = 1'b0; set_lu(1'b1, 5'd5, 32'hABCD);
    settle();
    check("t2_pend_set", pend_mask[5], 1'b1);
    check("t2_no_write_yet", rf_wen, 4'h0);
    next_cycle(); set_lu(1'b0, 5'd0, 32'd0);
    settle();
    check("t2_lu_wen", rf_wen, 4'hF);
    check("t2_lu_waddr", rf_waddr, 5'd5);
    check("t2_lu_wdata", rf_wdata, 32'hABCD);
    next_cycle();
    settle();
    check("t2_pend_clr", pend_mask[5], 1'b0);
    check("t2_idle_wen", rf_wen, 4'h0);

    // 3. two pushes while WB is busy every cycle: full, then a forced drain
    next_cycle(); set_wb(4'hF, 5'd9, 32'h99); set_lu(1'b1, 5'd10, 32'hA);
    settle();
    next_cycle(); set_lu(1'b1, 5'd11, 32'hB);
    settle();
    check("t3_ready_one", lu_ready, 1'b1);
    next_cycle(); set_lu(1'b1, 5'd12, 32'hC);
    settle();
    check("t3_full_ready", lu_ready, 1'b0);
    check("t3_wait2_stall", pipe_stall, 1'b0);
    next_cycle(); settle();
    check("t3_wait3_stall", pipe_stall, 1'b0);
    next_cycle(); settle();
    check("t3_wait4_stall", pipe_stall, 1'b0);
    next_cycle(); settle();
    check("t3_force_stall", pipe_stall, 1'b1);
    check("t3_force_wen", rf_wen, 4'hF);
    check("t3_force_waddr", rf_waddr, 5'd10);
    check("t3_force_wdata", rf_wdata, 32'hA);
    next_cycle(); settle();
    check("t3_after_stall", pipe_stall, 1'b0);
    check("t3_after_waddr", rf_waddr, 5'd9);
    check("t3_after_ready", lu_ready, 1'b1);
    next_cycle(); idle_inputs();
    repeat (4) next_cycle();

    // 4. push and pop together at occupancy DEPTH-1 across pointer wrap
    set_lu(1'b1, 5'd1, 32'h401);
    settle();
    for (int i = 1; i <= 8; i++) begin
      next_cycle(); set_lu(1'b1, 5'(i + 1), 32'h400 + 32'(i + 1));
      settle();
      check("t4_wen", rf_wen, 4'hF);
      check("t4_waddr", rf_waddr, 5'(i));
      check("t4_wdata", rf_wdata, 32'h400 + 32'(i));
      check("t4_ready", lu_ready, 1'b1);
    end
    next_cycle(); set_lu(1'b0, 5'd0, 32'd0);
    settle();
    check("t4_last_waddr", rf_waddr, 5'd9);
    check("t4_last_wdata", rf_wdata, 32'h409);
    next_cycle(); settle();
    check("t4_empty_wen", rf_wen, 4'h0);

    // 5. re-issue to a register in its retire cycle; WB to r0
    next_cycle(); lu_issue = 1'b1; lu_issue_addr = 5'd7;
    settle();
    next_cycle(); lu_issue = 1'b0; set_lu(1'b1, 5'd7, 32'h77);
    settle();
    check("t5_pend_set", pend_mask[7], 1'b1);
    next_cycle(); set_lu(1'b0, 5'd0, 32'd0); lu_issue = 1'b1; lu_issue_addr = 5'd7;
    settle();
    check("t5_retire_waddr", rf_waddr, 5'd7);
    next_cycle(); lu_issue = 1'b0; set_wb(4'hF, 5'd0, 32'h55);
    settle();
    check("t5_pend_kept", pend_mask[7], 1'b1);
    check("t5_r0_wen", rf_wen, 4'h0);

    // 6. reset asserted in FORCE with two entries buffered
    next_cycle(); set_wb(4'hF, 5'd9, 32'h99); set_lu(1'b1, 5'd13, 32'hD);
    settle();
    next_cycle(); set_lu(1'b1, 5'd14, 32'hE);
    settle();
    next_cycle(); set_lu(1'b0, 5'd0, 32'd0);
    settle();
    n = 0;
    while (pipe_stall !== 1'b1 && n < 10) begin
      next_cycle(); settle(); n++;
    end
    check("t6_force_reached", pipe_stall, 1'b1);
    resetn = 1'b0;
    #1;
    check("t6_rst_stall", pipe_stall, 1'b0);
    check("t6_rst_wen", rf_wen, 4'h0);
    check("t6_rst_ready", lu_ready, 1'b0);
    check("t6_rst_pend", pend_mask, 32'd0);
    next_cycle(); resetn = 1'b1; idle_inputs();
    settle();
    check("t6_rel_ready", lu_ready, 1'b1);
    check("t6_rel_wen", rf_wen, 4'h0);
    check("t6_rel_pend", pend_mask, 32'd0);
    next_cycle(); settle();
    check("t6_no_stale_drain", rf_wen, 4'h0);

    // Randomized traffic with valid/ready and stall-hold rules honoured
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      if (c == 1500) resetn = 1'b0;
      if (c == 1503) resetn = 1'b1;
      if (!(lu_valid && !ready_smp)) begin
        lu_valid = ($urandom_range(0, 9) < 4);
        lu_waddr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        lu_wdata = $urandom;
      end
      lu_issue      = ($urandom_range(0, 4) == 0);
      lu_issue_addr = 5'($urandom_range(0, 31));
      if (!stall_smp) begin
        ra = 5'($urandom_range(0, 31));
        wb_waddr = ra;
        wb_wdata = $urandom;
        if (((c / 300) % 2) == 0) wb_wen = ($urandom_range(0, 9) < 9) ? 4'($urandom_range(1, 15)) : 4'h0;
        else                      wb_wen = ($urandom_range(0, 9) < 3) ? 4'($urandom_range(1, 15)) : 4'h0;
        if (m_pend[ra]) wb_wen = 4'h0;
      end
    end
    next_cycle(); idle_inputs();
    repeat (6) next_cycle();
    settle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
